// File: rtl/mmio_responder.sv
// mmio_responder: device-side MMIO responder for the CPU MEM stage.
// Decodes io_* loads/stores into status/control registers and two word FIFOs.
//   clk, rst         : single clock, synchronous active-high reset
//   io_addr/io_dout  : CPU byte address (bits [1:0] ignored) and store data
//   io_we/io_rd      : one-cycle store / load strobes
//   io_din           : combinational load data (zero when io_rd is low)
//   sw, led          : raw switch inputs (2-flop synchronized) and LED register
//   in_valid/in_data/in_ready    : producer -> input FIFO (CPU pops at 0x08)
//   out_valid/out_data/out_ready : output FIFO (CPU pushes at 0x00) -> consumer
// Build option: define MMIO_RESP_ERR_EN to keep the sticky error register at 0x18.
module mmio_responder #(
  parameter int DEPTH = 8,
  parameter int SW_W  = 16,
  parameter int LED_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       io_addr,
  input  logic [31:0]      io_dout,
  input  logic             io_we,
  input  logic             io_rd,
  output logic [31:0]      io_din,
  input  logic [SW_W-1:0]  sw,
  output logic [LED_W-1:0] led,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_data,
  input  logic             out_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  localparam logic [7:0] A_OUT_DATA = 8'h00;
  localparam logic [7:0] A_OUT_STAT = 8'h04;
  localparam logic [7:0] A_IN_DATA  = 8'h08;
  localparam logic [7:0] A_IN_STAT  = 8'h0C;
  localparam logic [7:0] A_LED      = 8'h10;
  localparam logic [7:0] A_SW       = 8'h14;
  localparam logic [7:0] A_ERR      = 8'h18;
  localparam logic [7:0] A_CYCLE    = 8'h1C;

  logic [7:0] reg_sel;
  logic       rd_op;

  assign reg_sel = io_addr & 8'hFC;
  // A store takes priority: read side-effects are suppressed when both strobes are high.
  assign rd_op   = io_rd & ~io_we;

  // ---------------- input FIFO ----------------
  logic [31:0]   in_mem [DEPTH];
  logic [AW-1:0] in_wr, in_rd;
  logic [CW-1:0] in_cnt;
  logic          in_full, in_empty, in_push, in_pop;

  assign in_full  = (in_cnt == CNT_FULL);
  assign in_empty = (in_cnt == '0);
  assign in_ready = ~in_full;
  assign in_push  = in_valid & ~in_full;
  assign in_pop   = rd_op & (reg_sel == A_IN_DATA) & ~in_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_wr  <= '0;
      in_rd  <= '0;
      in_cnt <= '0;
    end else begin
      if (in_push) begin
        in_mem[in_wr] <= in_data;
        in_wr         <= in_wr + AW'(1);
      end
      if (in_pop) in_rd <= in_rd + AW'(1);
      case ({in_push, in_pop})
        2'b10:   in_cnt <= in_cnt + CW'(1);
        2'b01:   in_cnt <= in_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- output FIFO ----------------
  logic [31:0]   out_mem [DEPTH];
  logic [AW-1:0] out_wr, out_rd;
  logic [CW-1:0] out_cnt;
  logic          out_full, out_empty, out_push, out_pop;

  assign out_full  = (out_cnt == CNT_FULL);
  assign out_empty = (out_cnt == '0);
  assign out_valid = ~out_empty;
  // Gated so the head reads 0 while empty, since storage itself is not reset.
  assign out_data  = out_empty ? '0 : out_mem[out_rd];
  assign out_push  = io_we & (reg_sel == A_OUT_DATA) & ~out_full;
  assign out_pop   = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_wr  <= '0;
      out_rd  <= '0;
      out_cnt <= '0;
    end else begin
      if (out_push) begin
        out_mem[out_wr] <= io_dout;
        out_wr          <= out_wr + AW'(1);
      end
      if (out_pop) out_rd <= out_rd + AW'(1);
      case ({out_push, out_pop})
        2'b10:   out_cnt <= out_cnt + CW'(1);
        2'b01:   out_cnt <= out_cnt - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- LED, switches, cycle counter ----------------
  logic [SW_W-1:0] sw_s1, sw_s2;
  logic [31:0]     cycle;

  always_ff @(posedge clk) begin
    if (rst) begin
      led   <= '0;
      sw_s1 <= '0;
      sw_s2 <= '0;
      cycle <= '0;
    end else begin
      if (io_we && reg_sel == A_LED) led <= io_dout[LED_W-1:0];
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      cycle <= cycle + 32'd1;
    end
  end

  // ---------------- error register ----------------
  logic [1:0] err_rd;

`ifdef MMIO_RESP_ERR_EN
  logic [1:0] err;
  logic [1:0] err_set;
  logic       err_clr;

  assign err_set = {rd_op & (reg_sel == A_IN_DATA) & in_empty,
                    io_we & (reg_sel == A_OUT_DATA) & out_full};
  assign err_clr = rd_op & (reg_sel == A_ERR);

  // New errors OR in after the clear so a same-cycle event is not lost.
  always_ff @(posedge clk) begin
    if (rst) err <= '0;
    else     err <= (err_clr ? 2'b00 : err) | err_set;
  end

  assign err_rd = err;
`else
  assign err_rd = '0;
`endif

  // ---------------- read mux ----------------
  always_comb begin
    io_din = '0;
    if (io_rd) begin
      case (reg_sel)
        A_OUT_STAT: io_din = {22'b0, 9'(out_cnt), out_full};
        A_IN_DATA:  io_din = in_empty ? '0 : in_mem[in_rd];
        A_IN_STAT:  io_din = {22'b0, 9'(in_cnt), ~in_empty};
        A_LED:      io_din = 32'(led);
        A_SW:       io_din = 32'(sw_s2);
        A_ERR:      io_din = {30'b0, err_rd};
        A_CYCLE:    io_din = cycle;
        default:    io_din = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed self-checking bench for mmio_responder (DEPTH=8).
// Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
// Error-register expectations follow MMIO_RESP_ERR_EN.
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  io_addr;
  logic [31:0] io_dout;
  logic        io_we, io_rd;
  logic [31:0] io_din;
  logic [15:0] sw;
  logic [15:0] led;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

`ifdef MMIO_RESP_ERR_EN
  localparam logic [31:0] ERR_OVF = 32'h1;
  localparam logic [31:0] ERR_UDF = 32'h2;
`else
  localparam logic [31:0] ERR_OVF = 32'h0;
  localparam logic [31:0] ERR_UDF = 32'h0;
`endif

  mmio_responder #(.DEPTH(8), .SW_W(16), .LED_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .io_addr   (io_addr),
    .io_dout   (io_dout),
    .io_we     (io_we),
    .io_rd     (io_rd),
    .io_din    (io_din),
    .sw        (sw),
    .led       (led),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic        rd;
    logic [7:0]  addr;
    logic [31:0] dout;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_chk(input logic [7:0] a, input logic [31:0] e, input string nm);
    io_rd   = 1'b1;
    io_addr = a;
    @(negedge clk);
    chk(nm, io_din, e);
    step();
    io_rd = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    io_we   = 1'b1;
    io_addr = a;
    io_dout = d;
    step();
    io_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 8'h04, 32'h0,        32'h0,        "out_stat_rst"};
    tbl[1]  = '{1'b0, 1'b1, 8'h0C, 32'h0,        32'h0,        "in_stat_rst"};
    tbl[2]  = '{1'b0, 1'b1, 8'h10, 32'h0,        32'h0,        "led_rst"};
    tbl[3]  = '{1'b0, 1'b1, 8'h1C, 32'h0,        32'h3,        "cycle_after_rst"};
    tbl[4]  = '{1'b1, 1'b0, 8'h10, 32'h0000BEEF, 32'h0,        "led_wr"};
    tbl[5]  = '{1'b0, 1'b1, 8'h10, 32'h0,        32'h0000BEEF, "led_rd"};
    tbl[6]  = '{1'b0, 1'b1, 8'h00, 32'h0,        32'h0,        "out_data_rd_zero"};
    tbl[7]  = '{1'b0, 1'b1, 8'h20, 32'h0,        32'h0,        "unmapped_rd"};
    tbl[8]  = '{1'b1, 1'b0, 8'h20, 32'hFFFFFFFF, 32'h0,        "unmapped_wr"};
    tbl[9]  = '{1'b0, 1'b1, 8'h10, 32'h0,        32'h0000BEEF, "led_after_unmapped"};
    tbl[10] = '{1'b0, 1'b1, 8'hFF, 32'h0,        32'h0,        "addr_ff_rd"};
    tbl[11] = '{1'b0, 1'b1, 8'h13, 32'h0,        32'h0000BEEF, "led_low_bits_ignored"};
    tbl[12] = '{1'b0, 1'b1, 8'h18, 32'h0,        32'h0,        "err_clean"};

    rst = 1'b1; io_addr = 8'h1C; io_dout = '0; io_we = 1'b0; io_rd = 1'b0;
    sw = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // reset state, sampled while rst is still high
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    chk("rst_io_din_idle", io_din, 32'h0);
    step();
    rst = 1'b0;

    // register map vectors, first one in the first cycle after reset
    for (int i = 0; i < 13; i++) begin
      io_we   = tbl[i].we;
      io_rd   = tbl[i].rd;
      io_addr = tbl[i].addr;
      io_dout = tbl[i].dout;
      @(negedge clk);
      if (tbl[i].rd) chk(tbl[i].nm, io_din, tbl[i].exp);
      step();
    end
    io_we = 1'b0; io_rd = 1'b0;
    chk("led_port", 32'(led), 32'h0000BEEF);

    // input FIFO fill with 0xA0..0xA7, 0xA8 held off
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(k);
      @(negedge clk);
      chk($sformatf("in_ready_fill%0d", k), 32'(in_ready), 32'h1);
      step();
    end
    in_data = 32'hA8;
    @(negedge clk);
    chk("in_ready_full", 32'(in_ready), 32'h0);
    step();
    rd_chk(8'h0C, 32'h11, "in_stat_full");
    // pop while full: slot frees only for the next cycle
    io_rd = 1'b1; io_addr = 8'h08;
    @(negedge clk);
    chk("in_pop_a0", io_din, 32'hA0);
    chk("in_ready_pop_cycle", 32'(in_ready), 32'h0);
    step();
    io_rd = 1'b0;
    @(negedge clk);
    chk("in_ready_after_pop", 32'(in_ready), 32'h1);
    step();
    in_valid = 1'b0;
    rd_chk(8'h0C, 32'h11, "in_stat_refull");
    for (int k = 1; k < 8; k++)
      rd_chk(8'h08, 32'hA0 + 32'(k), $sformatf("in_pop_a%0d", k));
    rd_chk(8'h08, 32'hA8, "in_pop_a8");
    rd_chk(8'h0C, 32'h0, "in_stat_drained");

    // single entry, simultaneous push and pop, then empty read
    in_valid = 1'b1; in_data = 32'hC3;
    step();
    in_valid = 1'b0;
    rd_chk(8'h0C, 32'h3, "in_stat_one");
    io_we = 1'b1; io_rd = 1'b1; io_addr = 8'h08; io_dout = '0;
    step();
    io_we = 1'b0; io_rd = 1'b0;
    rd_chk(8'h0C, 32'h3, "in_stat_we_rd_nopop");
    in_valid = 1'b1; in_data = 32'hC4;
    rd_chk(8'h08, 32'hC3, "in_pushpop_head");
    in_valid = 1'b0;
    rd_chk(8'h0C, 32'h3, "in_stat_pushpop");
    rd_chk(8'h08, 32'hC4, "in_pushed_word");
    rd_chk(8'h08, 32'h0, "in_empty_rd");
    rd_chk(8'h18, ERR_UDF, "err_underflow");
    rd_chk(8'h18, 32'h0, "err_cleared_udf");

    // switch synchronizer latency
    sw = 16'h1234;
    rd_chk(8'h14, 32'h0, "sw_lat0");
    rd_chk(8'h14, 32'h0, "sw_lat1");
    rd_chk(8'h14, 32'h1234, "sw_lat2");
    rd_chk(8'h14, 32'h1234, "sw_lat3");

    // output FIFO fill with 0x11..0x19, consumer stalled
    for (int k = 0; k < 9; k++) begin
      io_we = 1'b1; io_addr = 8'h00; io_dout = 32'h11 + 32'(k);
      if (k == 0) begin
        @(negedge clk);
        chk("out_valid_no_bypass", 32'(out_valid), 32'h0);
      end
      step();
    end
    io_we = 1'b0;
    io_rd = 1'b1; io_addr = 8'h04;
    @(negedge clk);
    chk("out_stat_full", io_din, 32'h11);
    chk("out_valid_full", 32'(out_valid), 32'h1);
    chk("out_data_head", out_data, 32'h11);
    step();
    io_rd = 1'b0;
    rd_chk(8'h18, ERR_OVF, "err_overflow");
    rd_chk(8'h18, 32'h0, "err_cleared_ovf");

    // consumer drains five words
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("out_pop%0d", k), out_data, 32'h11 + 32'(k));
      step();
    end
    out_ready = 1'b0;
    rd_chk(8'h04, 32'h6, "out_stat_three");

    // reset mid-operation with a concurrent store and pop
    rst = 1'b1; out_ready = 1'b1;
    io_we = 1'b1; io_addr = 8'h00; io_dout = 32'hDEAD;
    step();
    rst = 1'b0; io_we = 1'b0;
    io_rd = 1'b1; io_addr = 8'h04;
    @(negedge clk);
    chk("out_stat_after_rst", io_din, 32'h0);
    chk("out_valid_after_rst", 32'(out_valid), 32'h0);
    chk("out_data_after_rst", out_data, 32'h0);
    chk("led_after_rst", 32'(led), 32'h0);
    step();
    io_rd = 1'b0;
    out_ready = 1'b0;
    rd_chk(8'h1C, 32'h1, "cycle_after_rst2");
    rd_chk(8'h0C, 32'h0, "in_stat_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
